mmio_timer_bank: RTL and testbench

Parametrised bank of NCH independent down-counting timers behind the memory-mapped I/O bus. It supersedes the fixed two-timer logic in the MMIO interface. Each channel has:
- a prescaler
- one-shot or auto-reload mode
- a sticky write-1-to-clear expiry flag and a per-channel interrupt enable

It sits behind the MMIO address decoder, which supplies `sel`, and drives the CPU interrupt lines.

---
 rtl/mmio_timer_bank.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_timer_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_timer_bank
// Brief    : Bank of NCH memory-mapped down-counting timers. Each channel has
//            a prescaler, one-shot/auto-reload mode, a sticky W1C expiry flag
//            and an interrupt enable.
// Revision : 1.0  initial release
// ============================================================================
module mmio_timer_bank #(
   parameter int NCH   = 4,
   parameter int W     = 16,
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             we,
   input  logic             re,
   input  logic [7:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rvalid,
   output logic [NCH-1:0]   irq,
   output logic             irq_any
);

   localparam logic [3:0] c_off_ctrl   = 4'h0;
   localparam logic [3:0] c_off_load   = 4'h4;
   localparam logic [3:0] c_off_count  = 4'h8;
   localparam logic [3:0] c_off_status = 4'hC;

   logic                  wr_acc;
   logic                  rd_acc;
   logic [3:0]            ch_idx;
   logic [3:0]            reg_off;

   // Per-channel readback words and interrupt sources
   logic [NCH-1:0][31:0]  ctrl_rb;
   logic [NCH-1:0][31:0]  load_rb;
   logic [NCH-1:0][31:0]  count_rb;
   logic [NCH-1:0][31:0]  status_rb;
   logic [NCH-1:0]        flag_vec;
   logic [NCH-1:0]        ie_vec;

   logic [31:0]           rd_word;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;

   // Upper write-data bits are not used by every parameterisation
   logic                  unused_wdata;

   assign wr_acc       = sel & we;
   assign rd_acc       = sel & re;
   assign ch_idx       = addr[7:4];
   assign reg_off      = addr[3:0];
   assign unused_wdata = ^wdata;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic              en_q, en_d;
         logic              reload_q, reload_d;
         logic              ie_q, ie_d;
         logic              flag_q, flag_d;
         logic [PRE_W-1:0]  prescale_q, prescale_d;
         logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
         logic [W-1:0]      load_q, load_d;
         logic [W-1:0]      count_q, count_d;
         logic              hit;
         logic              wr_ctrl;
         logic              wr_load;
         logic              wr_status;
         logic              active;
         logic              tick;
         logic              expire;

         assign hit       = (ch_idx == 4'(gi));
         assign wr_ctrl   = wr_acc & hit & (reg_off == c_off_ctrl);
         assign wr_load   = wr_acc & hit & (reg_off == c_off_load);
         assign wr_status = wr_acc & hit & (reg_off == c_off_status);
         assign active    = en_q & (count_q != '0);
         assign tick      = active & (pre_cnt_q == prescale_q);
         assign expire    = tick & (count_q == W'(1));

         // Counting, expiry and register writes; a bus write overrides the
         // tick's effect on COUNT and the prescaler
         always_comb begin
            en_d       = en_q;
            reload_d   = reload_q;
            ie_d       = ie_q;
            prescale_d = prescale_q;
            pre_cnt_d  = pre_cnt_q;
            load_d     = load_q;
            count_d    = count_q;

            if (active) begin
               pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
            end

            if (tick) begin
               if (expire) begin
                  if (reload_q) begin
                     count_d = load_q;
                  end else begin
                     count_d = '0;
                     en_d    = 1'b0;
                  end
               end else begin
                  count_d = count_q - W'(1);
               end
            end

            // Expiry set takes precedence over a simultaneous clear
            flag_d = expire | (flag_q & ~(wr_status & wdata[0]));

            if (wr_load) begin
               load_d    = wdata[W-1:0];
               count_d   = wdata[W-1:0];
               pre_cnt_d = '0;
            end

            if (wr_ctrl) begin
               en_d       = wdata[0];
               reload_d   = wdata[1];
               ie_d       = wdata[2];
               prescale_d = wdata[8 +: PRE_W];
               pre_cnt_d  = '0;
               // Enabling an expired/idle channel restarts it from LOAD
               count_d    = (wdata[0] & ~en_q & (count_q == '0)) ? load_q : count_q;
            end
         end

         // Channel state registers
         always_ff @(posedge clk) begin
            if (rst) begin
               en_q       <= 1'b0;
               reload_q   <= 1'b0;
               ie_q       <= 1'b0;
               flag_q     <= 1'b0;
               prescale_q <= '0;
               pre_cnt_q  <= '0;
               load_q     <= '0;
               count_q    <= '0;
            end else begin
               en_q       <= en_d;
               reload_q   <= reload_d;
               ie_q       <= ie_d;
               flag_q     <= flag_d;
               prescale_q <= prescale_d;
               pre_cnt_q  <= pre_cnt_d;
               load_q     <= load_d;
               count_q    <= count_d;
            end
         end

         assign ctrl_rb[gi]   = 32'({prescale_q, 5'b00000, ie_q, reload_q, en_q});
         assign load_rb[gi]   = 32'(load_q);
         assign count_rb[gi]  = 32'(count_q);
         assign status_rb[gi] = 32'({active, flag_q});
         assign flag_vec[gi]  = flag_q;
         assign ie_vec[gi]    = ie_q;
      end
   endgenerate

   // Read mux over current (pre-write) state; unmapped locations read 0
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch_idx == 4'(i)) begin
            case (reg_off)
               c_off_ctrl:   rd_word = ctrl_rb[i];
               c_off_load:   rd_word = load_rb[i];
               c_off_count:  rd_word = count_rb[i];
               c_off_status: rd_word = status_rb[i];
               default:      rd_word = '0;
            endcase
         end
      end
   end

   // Read response next state: capture on accepted read, otherwise hold
   always_comb begin
      rdata_d  = rd_acc ? rd_word : rdata_q;
      rvalid_d = rd_acc;
   end

   // Read response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;
   assign irq     = flag_vec & ie_vec;
   assign irq_any = |irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mmio_timer_bank
// Brief    : Directed self-checking bench for mmio_timer_bank: a vector table
//            for register access/decode plus sequences for timing corners.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_timer_bank;

   localparam int NCH   = 4;
   localparam int W     = 16;
   localparam int PRE_W = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            sel;
   logic            we;
   logic            re;
   logic [7:0]      addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            rvalid;
   logic [NCH-1:0]  irq;
   logic            irq_any;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit          w;
      bit          r;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] exp_rdata;
      bit          exp_rvalid;
   } vec_t;

   vec_t tbl [25];

   always #5 clk = ~clk;

   mmio_timer_bank #(
      .NCH   (NCH),
      .W     (W),
      .PRE_W (PRE_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .we      (we),
      .re      (re),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .irq     (irq),
      .irq_any (irq_any)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sel = 1'b0;
      we  = 1'b0;
      re  = 1'b0;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
      cyc();
      idle();
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
      sel = 1'b1; we = 1'b0; re = 1'b1; addr = a; wdata = '0;
      cyc();
      chk({name, " rvalid"}, 32'(rvalid), 32'd1);
      chk(name, rdata, exp);
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      chk("reset irq", 32'(irq), 32'd0);
      chk("reset irq_any", 32'(irq_any), 32'd0);
      chk("reset rvalid", 32'(rvalid), 32'd0);
      chk("reset rdata", rdata, 32'd0);
   endtask

   // Expected COUNT seen by back-to-back reads in auto-reload/prescale test
   int exp_cnt [10] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 3};
   // Isolation test: CTRL write cycle offset and LOAD per channel
   int iso_start [4] = '{0, 1, 2, 3};
   int iso_load  [4] = '{3, 5, 7, 4};

   initial begin
      //              w  r  addr   wdata          exp_rdata      rv
      tbl[0]  = '{1'b0, 1'b1, 8'h00, 32'h0,         32'h0,         1'b1};
      tbl[1]  = '{1'b0, 1'b1, 8'h04, 32'h0,         32'h0,         1'b1};
      tbl[2]  = '{1'b0, 1'b1, 8'h08, 32'h0,         32'h0,         1'b1};
      tbl[3]  = '{1'b0, 1'b1, 8'h0C, 32'h0,         32'h0,         1'b1};
      tbl[4]  = '{1'b0, 1'b1, 8'h3C, 32'h0,         32'h0,         1'b1};
      tbl[5]  = '{1'b1, 1'b0, 8'h04, 32'h0000_1234, 32'h0,         1'b0};
      tbl[6]  = '{1'b0, 1'b1, 8'h04, 32'h0,         32'h0000_1234, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 8'h08, 32'h0,         32'h0000_1234, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 8'h08, 32'h0000_0055, 32'h0000_1234, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 8'h08, 32'h0,         32'h0000_1234, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 8'h44, 32'h0000_0077, 32'h0000_1234, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 8'h40, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 8'h44, 32'h0,         32'h0,         1'b1};
      tbl[13] = '{1'b0, 1'b1, 8'h40, 32'h0,         32'h0,         1'b1};
      tbl[14] = '{1'b1, 1'b0, 8'h14, 32'h000A_BCDE, 32'h0,         1'b0};
      tbl[15] = '{1'b0, 1'b1, 8'h14, 32'h0,         32'h0000_BCDE, 1'b1};
      tbl[16] = '{1'b1, 1'b0, 8'h10, 32'hFFFF_FF06, 32'h0000_BCDE, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 8'h10, 32'h0,         32'h0000_FF06, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 8'h02, 32'hFFFF_FFFF, 32'h0000_FF06, 1'b0};
      tbl[19] = '{1'b0, 1'b1, 8'h02, 32'h0,         32'h0,         1'b1};
      tbl[20] = '{1'b0, 1'b1, 8'h00, 32'h0,         32'h0,         1'b1};
      tbl[21] = '{1'b0, 1'b1, 8'h1C, 32'h0,         32'h0,         1'b1};
      tbl[22] = '{1'b1, 1'b1, 8'h04, 32'h0000_0042, 32'h0000_1234, 1'b1};
      tbl[23] = '{1'b0, 1'b1, 8'h04, 32'h0,         32'h0000_0042, 1'b1};
      tbl[24] = '{1'b0, 1'b0, 8'h00, 32'h0,         32'h0000_0042, 1'b0};

      idle();
      addr  = '0;
      wdata = '0;
      rst   = 1'b0;

      // ---------------- reset + table-driven register/decode vectors
      do_reset();
      for (int i = 0; i < 25; i++) begin
         sel   = tbl[i].w | tbl[i].r;
         we    = tbl[i].w;
         re    = tbl[i].r;
         addr  = tbl[i].a;
         wdata = tbl[i].d;
         cyc();
         chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rdata);
         chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(tbl[i].exp_rvalid));
         chk($sformatf("vec%0d irq", i), 32'(irq), 32'd0);
      end
      idle();

      // ---------------- one-shot: FLAG/irq exactly 5 cycles after CTRL write
      do_reset();
      bus_wr(8'h04, 32'd5);
      bus_wr(8'h00, 32'h5);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk($sformatf("oneshot irq k=%0d", k), 32'(irq), (k == 5) ? 32'h1 : 32'h0);
      end
      rd_chk("oneshot ctrl", 8'h00, 32'h4);
      rd_chk("oneshot count", 8'h08, 32'h0);
      chk("oneshot irq_any", 32'(irq_any), 32'd1);
      rd_chk("oneshot status", 8'h0C, 32'h1);

      // ---------------- auto-reload with prescale 2 on channel 1
      do_reset();
      bus_wr(8'h14, 32'd3);
      bus_wr(8'h10, 32'h0203);
      for (int k = 1; k <= 10; k++) begin
         rd_chk($sformatf("reload count k=%0d", k), 8'h18, 32'(exp_cnt[k-1]));
      end
      rd_chk("reload status set", 8'h1C, 32'h3);
      chk("reload irq masked", 32'(irq), 32'd0);
      bus_wr(8'h1C, 32'h1);
      rd_chk("reload status cleared", 8'h1C, 32'h2);
      for (int k = 14; k <= 19; k++) begin
         rd_chk($sformatf("reload period k=%0d", k), 8'h1C, (k == 19) ? 32'h3 : 32'h2);
      end

      // ---------------- W1C deasserts next cycle; W1C on expiry loses
      do_reset();
      bus_wr(8'h24, 32'd2);
      bus_wr(8'h20, 32'h7);
      cyc();
      chk("w1c irq before expiry", 32'(irq), 32'h0);
      cyc();
      chk("w1c irq first expiry", 32'(irq), 32'h4);
      bus_wr(8'h2C, 32'h1);
      chk("w1c irq cleared", 32'(irq), 32'h0);
      chk("w1c irq_any cleared", 32'(irq_any), 32'h0);
      bus_wr(8'h2C, 32'h1);
      chk("w1c vs expiry irq", 32'(irq), 32'h4);
      chk("w1c vs expiry irq_any", 32'(irq_any), 32'h1);

      // ---------------- LOAD write on a tick cycle: no decrement
      do_reset();
      bus_wr(8'h34, 32'd10);
      bus_wr(8'h30, 32'h1);
      cyc();
      bus_wr(8'h34, 32'd7);
      rd_chk("load-on-tick count", 8'h38, 32'd7);
      rd_chk("load-on-tick next", 8'h38, 32'd6);
      rd_chk("load-on-tick load", 8'h34, 32'd7);

      // ---------------- channel isolation
      do_reset();
      for (int i = 0; i < NCH; i++) bus_wr(8'(i * 16 + 4), 32'(iso_load[i]));
      for (int i = 0; i < NCH; i++) bus_wr(8'(i * 16), 32'h5);
      for (int k = 3; k <= 10; k++) begin
         logic [31:0] exp_irq;
         if (k > 3) cyc();
         exp_irq = '0;
         for (int i = 0; i < NCH; i++) begin
            if (k >= iso_start[i] + iso_load[i]) exp_irq[i] = 1'b1;
         end
         chk($sformatf("isolation irq k=%0d", k), 32'(irq), exp_irq);
      end

      // ---------------- reset held mid-count aborts everything
      bus_wr(8'h04, 32'd100);
      bus_wr(8'h00, 32'h5);
      cyc();
      cyc();
      do_reset();
      rd_chk("post-reset ctrl", 8'h00, 32'h0);
      rd_chk("post-reset load", 8'h04, 32'h0);
      rd_chk("post-reset count", 8'h08, 32'h0);
      rd_chk("post-reset status", 8'h0C, 32'h0);
      cyc();
      chk("idle rvalid", 32'(rvalid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
